// File: rtl/param_cpu_pkg.sv
// Shared opcode, state and field-width definitions for the parametrised accumulator CPU.
package param_cpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADC = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h4;
    localparam logic [OPC_W-1:0] OP_AND = 4'h5;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h6;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h7;
    localparam logic [OPC_W-1:0] OP_SHL = 4'h8;
    localparam logic [OPC_W-1:0] OP_SHR = 4'h9;
    localparam logic [OPC_W-1:0] OP_JMP = 4'hA;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'hB;
    localparam logic [OPC_W-1:0] OP_JC  = 4'hC;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hD;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_e;

endpackage

// File: rtl/param_cpu_prog_mem.sv
// Program store: one write port, registered read port, contents survive reset.
module param_cpu_prog_mem
    import param_cpu_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [PC_W-1:0]         waddr_i,
    input  logic [OPC_W+DATA_W-1:0] wdata_i,
    input  logic [PC_W-1:0]         raddr_i,
    output logic [OPC_W+DATA_W-1:0] rdata_o
);

    logic [OPC_W+DATA_W-1:0] mem_q [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/param_cpu.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXECUTE over a writable program memory.
//   state     | meaning
//   S_IDLE    | after reset, waiting for start; program port open
//   S_FETCH   | memory reads mem[pc]
//   S_DECODE  | instruction register captures read data
//   S_EXECUTE | acc/flags/pc/y update
//   S_HALT    | stopped by HLT; program port open, start restarts at pc=0
module param_cpu
    import param_cpu_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int PROG_DEPTH = 16,
    localparam int PC_W      = $clog2(PROG_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    prog_we,
    input  logic [PC_W-1:0]         prog_addr,
    input  logic [OPC_W+DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0]       y,
    output logic                    y_valid,
    output logic                    busy,
    output logic                    halted,
    output logic [PC_W-1:0]         pc,
    output logic [1:0]              flags
);

    localparam int WORD_W = OPC_W + DATA_W;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                c_q, c_d;
    logic                z_q, z_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic                y_valid_q, y_valid_d;

    logic [WORD_W-1:0]   mem_rdata;
    logic                mem_we;
    logic [OPC_W-1:0]    opc;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W:0]     sum_add, sum_adc, diff;
    logic [DATA_W-1:0]   res_and, res_or, res_xor;

    // Loads are only safe while nothing is fetching.
    assign mem_we = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

    param_cpu_prog_mem #(
        .DATA_W     (DATA_W),
        .PROG_DEPTH (PROG_DEPTH),
        .PC_W       (PC_W)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    assign opc     = ir_q[WORD_W-1:DATA_W];
    assign imm     = ir_q[DATA_W-1:0];
    assign sum_add = {1'b0, acc_q} + {1'b0, imm};
    assign sum_adc = {1'b0, acc_q} + {1'b0, imm} + {{DATA_W{1'b0}}, c_q};
    assign diff    = {1'b0, acc_q} - {1'b0, imm};
    assign res_and = acc_q & imm;
    assign res_or  = acc_q | imm;
    assign res_xor = acc_q ^ imm;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        c_d       = c_q;
        z_d       = z_q;
        ir_d      = ir_q;
        y_d       = y_q;
        y_valid_d = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    acc_d   = '0;
                    c_d     = 1'b0;
                    z_d     = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = mem_rdata;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_W'(1);
                case (opc)
                    OP_LDI: acc_d = imm;
                    OP_ADD: begin
                        {c_d, acc_d} = sum_add;
                        z_d          = (sum_add[DATA_W-1:0] == '0);
                    end
                    OP_ADC: begin
                        {c_d, acc_d} = sum_adc;
                        z_d          = (sum_adc[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        acc_d = diff[DATA_W-1:0];
                        c_d   = diff[DATA_W];
                        z_d   = (diff[DATA_W-1:0] == '0);
                    end
                    OP_AND: begin
                        acc_d = res_and;
                        z_d   = (res_and == '0);
                    end
                    OP_OR: begin
                        acc_d = res_or;
                        z_d   = (res_or == '0);
                    end
                    OP_XOR: begin
                        acc_d = res_xor;
                        z_d   = (res_xor == '0);
                    end
                    OP_SHL: begin
                        c_d   = acc_q[DATA_W-1];
                        acc_d = {acc_q[DATA_W-2:0], 1'b0};
                        z_d   = (acc_q[DATA_W-2:0] == '0);
                    end
                    OP_SHR: begin
                        c_d   = acc_q[0];
                        acc_d = {1'b0, acc_q[DATA_W-1:1]};
                        z_d   = (acc_q[DATA_W-1:1] == '0);
                    end
                    OP_JMP: pc_d = PC_W'(imm);
                    OP_JZ:  if (z_q) pc_d = PC_W'(imm);
                    OP_JC:  if (c_q) pc_d = PC_W'(imm);
                    OP_OUT: begin
                        y_d       = acc_q;
                        y_valid_d = 1'b1;
                    end
                    OP_HLT: state_d = S_HALT;
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            acc_q     <= '0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            ir_q      <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            c_q       <= c_d;
            z_q       <= z_d;
            ir_q      <= ir_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE);
    assign halted  = (state_q == S_HALT);
    assign pc      = pc_q;
    assign flags   = {c_q, z_q};

endmodule

// File: tb/tb_param_cpu.sv
// Bench for param_cpu: directed programs plus random programs against an instruction-level model.
module tb_param_cpu;

    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int PW    = 4;
    localparam int MOD   = 1 << DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          prog_we;
    logic [PW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [DW-1:0] y;
    logic          y_valid;
    logic          busy;
    logic          halted;
    logic [PW-1:0] pc;
    logic [1:0]    flags;

    param_cpu #(.DATA_W(DW), .PROG_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .y         (y),
        .y_valid   (y_valid),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cnt_pc2  = 0;

    // Reference machine: 0 idle, 1 running, 2 halted.
    int m_mem [DEPTH];
    int m_state, m_pc, m_acc, m_c, m_z, m_y, m_yv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_y = 0; m_yv = 0;
    endtask

    task automatic m_step();
        int op, imm, npc, s;
        op  = m_mem[m_pc] / 16;
        imm = m_mem[m_pc] % 16;
        npc = (m_pc + 1) % DEPTH;
        m_yv = 0;
        case (op)
            1: m_acc = imm;
            2: begin s = m_acc + imm;       m_c = (s >= MOD); m_acc = s % MOD; m_z = (m_acc == 0); end
            3: begin s = m_acc + imm + m_c; m_c = (s >= MOD); m_acc = s % MOD; m_z = (m_acc == 0); end
            4: begin m_c = (m_acc < imm); m_acc = (m_acc - imm + MOD) % MOD; m_z = (m_acc == 0); end
            5: begin m_acc = m_acc & imm; m_z = (m_acc == 0); end
            6: begin m_acc = m_acc | imm; m_z = (m_acc == 0); end
            7: begin m_acc = m_acc ^ imm; m_z = (m_acc == 0); end
            8: begin m_c = (m_acc >= MOD/2); m_acc = (m_acc * 2) % MOD; m_z = (m_acc == 0); end
            9: begin m_c = m_acc % 2; m_acc = m_acc / 2; m_z = (m_acc == 0); end
            10: npc = imm % DEPTH;
            11: if (m_z != 0) npc = imm % DEPTH;
            12: if (m_c != 0) npc = imm % DEPTH;
            13: begin m_y = m_acc; m_yv = 1; end
            14: m_state = 2;
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_pc"},     32'(pc),      32'(m_pc));
        chk({tag, "_flags"},  32'(flags),   32'(m_c * 2 + m_z));
        chk({tag, "_y"},      32'(y),       32'(m_y));
        chk({tag, "_yv"},     32'(y_valid), 32'(m_yv));
        chk({tag, "_busy"},   32'(busy),    32'(m_state == 1));
        chk({tag, "_halted"}, 32'(halted),  32'(m_state == 2));
    endtask

    task automatic load_word(input int a, input int w);
        prog_we   = 1'b1;
        prog_addr = PW'(a);
        prog_data = 8'(w);
        if (m_state != 1) m_mem[a] = w;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        check_outputs(tag);
    endtask

    // Starts the program and follows it instruction by instruction, checking every cycle.
    task automatic run(input string tag, input int max_instr, input bit poke);
        start = 1'b1;
        if (m_state != 1) begin
            m_state = 1; m_pc = 0; m_acc = 0; m_c = 0; m_z = 0;
        end
        m_yv = 0;
        @(negedge clk);
        start = 1'b0;
        check_outputs({tag, "_start"});
        for (int i = 0; i < max_instr; i++) begin
            if (poke && i == 1) begin
                prog_we = 1'b1; prog_addr = '0; prog_data = 8'hE0; start = 1'b1;
            end
            @(negedge clk);
            prog_we = 1'b0; start = 1'b0;
            chk({tag, "_yv_dec"}, 32'(y_valid), 0);
            chk({tag, "_busy_dec"}, 32'(busy), 1);
            @(negedge clk);
            chk({tag, "_yv_exe"}, 32'(y_valid), 0);
            @(negedge clk);
            m_step();
            check_outputs(tag);
            if (pc == 4'd2) cnt_pc2++;
            if (m_state == 2) break;
        end
        if (m_state == 2) begin
            @(negedge clk);
            m_yv = 0;
            check_outputs({tag, "_post"});
        end
    endtask

    task automatic load_basic();
        load_word(0, 8'h13); load_word(1, 8'h25); load_word(2, 8'hD0); load_word(3, 8'hE0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs("reset");
        for (int i = 0; i < DEPTH; i++) load_word(i, 0);

        // Basic LDI/ADD/OUT/HLT
        load_basic();
        run("basic", 10, 1'b0);
        chk("basic_y", 32'(y), 8);
        chk("basic_halted", 32'(halted), 1);

        // Carry and zero into a taken JC
        load_word(0, 8'h1F); load_word(1, 8'h21); load_word(2, 8'hC5);
        load_word(3, 8'hE0); load_word(4, 8'hE0); load_word(5, 8'hD0); load_word(6, 8'hE0);
        run("carry", 10, 1'b0);
        chk("carry_flags", 32'(flags), 3);
        chk("carry_y", 32'(y), 0);

        // Countdown loop
        load_word(0, 8'h13); load_word(1, 8'h41); load_word(2, 8'hB4);
        load_word(3, 8'hA1); load_word(4, 8'hE0);
        cnt_pc2 = 0;
        run("count", 30, 1'b0);
        chk("count_subs", 32'(cnt_pc2), 3);
        chk("count_halted", 32'(halted), 1);

        // All reserved opcodes: pc wraps, nothing else moves
        for (int i = 0; i < DEPTH; i++) load_word(i, 8'hF0 + i);
        run("wrap", 20, 1'b0);
        do_reset("wrap_rst");

        // Reset during EXECUTE of ADD
        load_basic();
        for (int i = 4; i < DEPTH; i++) load_word(i, 8'hE0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        do_reset("midrst");
        run("rerun", 10, 1'b0);
        chk("rerun_y", 32'(y), 8);

        // Writes and start while busy are ignored; a write in HALT sticks
        run("prot", 10, 1'b1);
        run("prot2", 10, 1'b0);
        chk("prot2_y", 32'(y), 8);
        load_word(0, 8'h17);
        run("prot3", 10, 1'b0);
        chk("prot3_y", 32'(y), 12);

        // Random programs
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < DEPTH; i++) load_word(i, int'($urandom_range(255, 0)));
            run("rand", 30, 1'b0);
            if (m_state == 1) do_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_cpu.md
Name: param_cpu

Overview:
- Parametrised successor to the fixed 4-bit fetch/execute CPU.
- Multi-cycle accumulator machine with an on-chip, writable program memory.
- Adds: configurable data width and program depth, Z/C flags, conditional/unconditional jumps, explicit output strobe, halt, and a start/load control interface.
- Sits at the top of the CPU subsystem; the bench or a loader drives the program port.

Parameters:
- DATA_W, 4: accumulator, immediate and output width (>=4).
- PROG_DEPTH, 16: program words; power of 2, >=2.
- PC_W, $clog2(PROG_DEPTH): program counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from pc=0 when in IDLE or HALT.
- prog_we  in  1  program write enable.
- prog_addr  in  PC_W  program write address.
- prog_data  in  4+DATA_W  instruction word {opcode[3:0], imm[DATA_W-1:0]}.
- y  out  DATA_W  output register.
- y_valid  out  1  one-cycle strobe when y is updated.
- busy  out  1  high in FETCH/DECODE/EXECUTE.
- halted  out  1  high in HALT.
- pc  out  PC_W  current program counter (debug).
- flags  out  2  {C,Z} (debug).

Behaviour:
- Reset: state=IDLE, pc=0, acc=0, C=Z=0, y=0, y_valid=0, busy=0, halted=0. Program memory is not cleared. Reset mid-instruction aborts it with no writeback.
- FSM: IDLE -start-> FETCH -> DECODE -> EXECUTE -> FETCH, or EXECUTE(HLT) -> HALT. HALT -start-> FETCH. start is ignored in every other state.
- start accepted: pc, acc, C and Z clear. y keeps its value.
- FETCH: synchronous read of mem[pc]. DECODE: ir <= read data. EXECUTE: update acc/flags/pc. Each instruction takes exactly 3 cycles.
- pc <= pc+1 in EXECUTE unless a jump is taken. Wraps PROG_DEPTH-1 -> 0.
- Opcodes:
  - 0 NOP
  - 1 LDI: acc=imm
  - 2 ADD: {C,acc}=acc+imm
  - 3 ADC: {C,acc}=acc+imm+C
  - 4 SUB: acc=acc-imm; C=borrow (acc<imm)
  - 5 AND; 6 OR; 7 XOR
  - 8 SHL: C=acc[MSB], acc<<=1
  - 9 SHR: C=acc[0], acc>>=1
  - A JMP; B JZ; C JC: target=imm[PC_W-1:0], taken if the condition holds, flags unchanged
  - D OUT: y<=acc and y_valid=1 in the cycle after EXECUTE
  - E HLT
  - F reserved, treated as NOP
- Flags: arithmetic, logic and shift ops update Z=(result==0). Only ADD/ADC/SUB/SHL/SHR write C; logic ops leave C unchanged. LDI, jumps, OUT and NOP leave flags unchanged.
- Immediates wider than PC_W are truncated for jumps. All arithmetic is modulo 2^DATA_W.
- y_valid: single-cycle pulse, never high two cycles running.
- prog_we: honoured only in IDLE or HALT; ignored while busy=1. A write and a start in the same cycle perform the write, then start.
- Simultaneous reset and start: reset wins.

Decomposition:
- Package param_cpu_pkg holds: opcode localparams (OP_NOP..OP_HLT), state encoding (S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT), and the instruction field slicing constant OPC_W=4.
- Sub-module prog_mem: single-port write, synchronous-read array of PROG_DEPTH x (4+DATA_W), no reset.
- ALU/flag logic stays inline in the EXECUTE datapath.

Test Plan:
- Basic sequence (DATA_W=4): load LDI 3; ADD 5; OUT; HLT, then pulse start at cycle 0 -> y=8 with y_valid high only in cycle 10, halted=1 from cycle 13, busy=0.
- Carry/zero: LDI F; ADD 1; JC 5; place OUT at address 5 -> acc=0, flags={C,Z}=2'b11, pc jumps to 5, y=0 strobed.
- Countdown loop: LDI 3; SUB 1; JZ 4; JMP 1; HLT -> exactly 3 SUB executions, then halted. Z low after the first two SUBs, high after the third.
- Wrap and reserved opcode: fill all 16 words with opcode F -> pc sequence 0..15,0,1,... and acc/flags never change.
- Reset mid-run: assert reset during the EXECUTE of ADD -> next cycle state=IDLE, acc=0, pc=0. Program memory is intact; a restart reproduces the first test's result.
- Load protection: prog_we to address 0 while busy=1 is ignored. The same write in HALT takes effect, and a restart runs the new word.
